// File: rtl/ivl_uvm_ovl_pkg.sv
// Shared types and helpers for the ivl_uvm OVL overflow/underflow checker.
// Optional messaging in the checker files is enabled by IVL_UVM_OVL_NO_OVERFLOW_MSG_EN.
package ivl_uvm_ovl_pkg;

    typedef enum int {
        OVL_OVF_OVER  = 0,
        OVL_OVF_UNDER = 1,
        OVL_OVF_BOTH  = 2
    } ovl_ovf_mode_e;

    typedef enum logic [1:0] {
        BND_IDLE,
        BND_AT_MAX,
        BND_AT_MIN
    } ovl_bnd_state_e;

    // cur + popcount(hits), clamped to lim; a 33-bit sum keeps the add from wrapping
    function automatic logic [31:0] popcount_sat(input logic [31:0] cur,
                                                 input logic [31:0] hits,
                                                 input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, cur};
        for (int i = 0; i < 32; i++) begin
            sum = sum + 33'(hits[i]);
        end
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/ivl_uvm_ovl_ovf_chan.sv
// One monitored channel: boundary state, previous sample and the violation compare.
// With IVL_UVM_OVL_NO_OVERFLOW_MSG_EN defined each violation prints an $error.
module ivl_uvm_ovl_ovf_chan
    import ivl_uvm_ovl_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int unsigned MIN   = 0,
    parameter int unsigned MAX   = 255,
    parameter int          MODE  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample,
    output logic             viol
);

    localparam logic [WIDTH-1:0] MIN_V = MIN[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
    localparam bit CHK_OVER  = (MODE == int'(OVL_OVF_OVER))  || (MODE == int'(OVL_OVF_BOTH));
    localparam bit CHK_UNDER = (MODE == int'(OVL_OVF_UNDER)) || (MODE == int'(OVL_OVF_BOTH));

    ovl_bnd_state_e   state, state_nxt;
    logic [WIDTH-1:0] prev;
    logic             prev_vld;
    logic             ovf, unf;

    always_comb begin
        state_nxt = BND_IDLE;
        ovf       = 1'b0;
        unf       = 1'b0;
        // unknown samples neither fire nor arm the channel
        if (enable && !$isunknown(sample)) begin
            if (sample == MAX_V) begin
                state_nxt = BND_AT_MAX;
            end else if (sample == MIN_V) begin
                state_nxt = BND_AT_MIN;
            end
            if (prev_vld) begin
                ovf = CHK_OVER && (state == BND_AT_MAX) && (prev == MAX_V) &&
                      ((sample > MAX_V) || (sample <= MIN_V));
                unf = CHK_UNDER && (state == BND_AT_MIN) && (prev == MIN_V) &&
                      ((sample < MIN_V) || (sample >= MAX_V));
            end
        end
        viol = ovf || unf;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= BND_IDLE;
            prev     <= '0;
            prev_vld <= 1'b0;
        end else if (!enable) begin
            state    <= BND_IDLE;
            prev_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            prev     <= sample;
            prev_vld <= 1'b1;
        end
    end

`ifdef IVL_UVM_OVL_NO_OVERFLOW_MSG_EN
    always_ff @(posedge clock) begin
        if (!reset && viol) begin
            $error("%t %m channel violation prev=%0d cur=%0d %s", $time, prev, sample,
                   ovf ? "OVERFLOW" : "UNDERFLOW");
        end
    end
`endif

endmodule

// File: rtl/ivl_uvm_ovl_no_overflow_mc.sv
// Multi-channel overflow/underflow checker: per-channel pulses, sticky flags, count, first offender.
// With IVL_UVM_OVL_NO_OVERFLOW_MSG_EN defined, violations and counter saturation are reported.
module ivl_uvm_ovl_no_overflow_mc
    import ivl_uvm_ovl_pkg::*;
#(
    parameter int          WIDTH  = 8,
    parameter int          NUM_CH = 4,
    parameter int unsigned MIN    = 0,
    parameter int unsigned MAX    = 255,
    parameter int          MODE   = 0,
    parameter int          CNT_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH*WIDTH-1:0]   test_expr,
    input  logic                      clear,
    output logic [NUM_CH-1:0]         fire,
    output logic [NUM_CH-1:0]         fire_sticky,
    output logic [CNT_W-1:0]          fire_cnt,
    output logic [$clog2(NUM_CH):0]   first_ch,
    output logic                      first_vld
);

    localparam int          FC_W    = $clog2(NUM_CH) + 1;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    if (MIN >= MAX) begin : g_bad_bounds
        $fatal(1, "ivl_uvm_ovl_no_overflow_mc: MIN must be below MAX");
    end
    if (64'(MAX) >= (64'd1 << WIDTH)) begin : g_bad_max
        $fatal(1, "ivl_uvm_ovl_no_overflow_mc: MAX does not fit in WIDTH bits");
    end
    if (NUM_CH < 1 || NUM_CH > 32 || CNT_W < 1 || CNT_W > 32) begin : g_bad_size
        $fatal(1, "ivl_uvm_ovl_no_overflow_mc: NUM_CH and CNT_W must be 1..32");
    end

    logic [NUM_CH-1:0] viol;
    logic [FC_W-1:0]   low_idx;
    logic [CNT_W-1:0]  cnt_base, cnt_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ivl_uvm_ovl_ovf_chan #(
            .WIDTH (WIDTH),
            .MIN   (MIN),
            .MAX   (MAX),
            .MODE  (MODE)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .enable (enable),
            .sample (test_expr[i*WIDTH +: WIDTH]),
            .viol   (viol[i])
        );
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (viol[i]) low_idx = FC_W'(i);
        end
        // clear zeroes the base first so the same cycle's violations still count
        cnt_base = clear ? '0 : fire_cnt;
        cnt_nxt  = CNT_W'(popcount_sat(32'(cnt_base), 32'(viol), CNT_MAX));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fire        <= '0;
            fire_sticky <= '0;
            fire_cnt    <= '0;
            first_ch    <= '0;
            first_vld   <= 1'b0;
        end else begin
            fire        <= viol;
            fire_sticky <= (clear ? '0 : fire_sticky) | viol;
            fire_cnt    <= cnt_nxt;
            if (clear) begin
                first_ch  <= '0;
                first_vld <= 1'b0;
            end
            if ((clear || !first_vld) && (|viol)) begin
                first_ch  <= low_idx;
                first_vld <= 1'b1;
            end
        end
    end

`ifdef IVL_UVM_OVL_NO_OVERFLOW_MSG_EN
    always_ff @(posedge clock) begin
        if (!reset && (fire_cnt != CNT_W'(CNT_MAX)) && (cnt_nxt == CNT_W'(CNT_MAX))) begin
            $warning("%t %m fire_cnt saturated at %0d", $time, cnt_nxt);
        end
    end
`endif

endmodule
